sram_b_banked_1w1r: RTL and testbench

Parametrised one-write/one-read banked SRAM for accelerator private local memories. It builds a logical ABITS x DBITS memory from a grid of dual-port BRAM banks: vertical banks selected by the upper address bits, horizontal slices by data bit. Over the fixed 18-bit/8-bit generation it adds:
- same-cycle write-to-read bypass;
- an optional output register stage;
- a read-valid output;
- reset-defined outputs.

---
 rtl/sram_b_pkg.sv | 44 ++++
 rtl/sram_b_banked_1w1r_if.sv | 26 ++
 rtl/sram_b_bank.sv | 50 +++++
 rtl/sram_b_banked_1w1r.sv | 207 ++++++++++++++++++++
 tb/tb_sram_b_banked_1w1r.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_b_pkg.sv
// sram_b_pkg: shared types and geometry helpers for the banked 1W1R SRAM.
// Exposes nv()/nh() grid sizing, BANK_SEL_W and the bank-port bundle.
package sram_b_pkg;

  // Widest bank address / data the bank bundle can carry.
  localparam int BANK_AW_MAX = 16;
  localparam int BANK_DW_MAX = 40;

  // Widest vertical-bank select (up to 256 vertical banks).
  localparam int BANK_SEL_W = 8;

  typedef struct packed {
    logic                   ce;
    logic [BANK_AW_MAX-1:0] a;
    logic [BANK_DW_MAX-1:0] d;
    logic                   we;
    logic [BANK_DW_MAX-1:0] wem;
  } bank_port_t;

  function automatic int nv(int abits, int babits);
    return 1 << (abits - babits);
  endfunction

  function automatic int nh(int dbits, int bdbits);
    return (dbits + bdbits - 1) / bdbits;
  endfunction

  // Register width for the vertical index; 1 even with one bank.
  function automatic int sel_w(int abits, int babits);
    return (abits > babits) ? abits - babits : 1;
  endfunction

  // Geometries for which a BRAM_<depth>x<width> primitive exists.
  function automatic bit bram_ok(int babits, int bdbits);
    bit w_ok;
    case (bdbits)
      1, 2, 4, 8, 9, 16, 18, 32, 36: w_ok = 1'b1;
      default:                       w_ok = 1'b0;
    endcase
    return w_ok && (babits >= 9) && (babits < BANK_AW_MAX) &&
           (((1 << babits) * bdbits) <= 36864);
  endfunction

endpackage

// File: rtl/sram_b_banked_1w1r_if.sv
// sram_b_banked_1w1r_if: write port (CE0/A0/D0/WE0/WEM0) and read port
// (CE1/A1 -> Q1/Q1_VALID); master drives requests, slave is the memory.
interface sram_b_banked_1w1r_if #(
  parameter int ABITS = 18,
  parameter int DBITS = 8
);
  logic             CE0;
  logic [ABITS-1:0] A0;
  logic [DBITS-1:0] D0;
  logic             WE0;
  logic [DBITS-1:0] WEM0;
  logic             CE1;
  logic [ABITS-1:0] A1;
  logic [DBITS-1:0] Q1;
  logic             Q1_VALID;

  modport master (
    output CE0, A0, D0, WE0, WEM0, CE1, A1,
    input  Q1, Q1_VALID
  );

  modport slave (
    input  CE0, A0, D0, WE0, WEM0, CE1, A1,
    output Q1, Q1_VALID
  );
endinterface

// File: rtl/sram_b_bank.sv
// sram_b_bank: one dual-port BRAM_<2^ABITS>x<DBITS> cell; p0 writes with a
// bit mask, p1 reads synchronously into q1. Unsupported geometry: elab error.
import sram_b_pkg::*;

module sram_b_bank #(
  parameter int ABITS = 14,
  parameter int DBITS = 1
) (
  input  logic             CLK,
  input  bank_port_t       p0,
  input  bank_port_t       p1,
  output logic [DBITS-1:0] q1
);

  localparam int DEPTH = 1 << ABITS;

  if (!bram_ok(ABITS, DBITS)) begin : g_bad_geom
    $error("sram_b_bank: no BRAM for %0dx%0d", DEPTH, DBITS);
  end

  logic [DBITS-1:0] mem [DEPTH];

  logic [ABITS-1:0] wa, ra;
  logic [DBITS-1:0] wd, wm;

  assign wa = p0.a[ABITS-1:0];
  assign wd = p0.d[DBITS-1:0];
  assign wm = p0.wem[DBITS-1:0];
  assign ra = p1.a[ABITS-1:0];

  // Read-before-write: a same-address read sees the old word.
  always_ff @(posedge CLK) begin
    if (p0.ce && p0.we) begin
      mem[wa] <= (mem[wa] & ~wm) | (wd & wm);
    end
    if (p1.ce) begin
      q1 <= mem[ra];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{
    p0.a[BANK_AW_MAX-1:ABITS],
    p0.d[BANK_DW_MAX-1:DBITS],
    p0.wem[BANK_DW_MAX-1:DBITS],
    p1.a[BANK_AW_MAX-1:ABITS],
    p1.d, p1.we, p1.wem
  };

endmodule

// File: rtl/sram_b_banked_1w1r.sv
// sram_b_banked_1w1r: ABITS x DBITS 1W1R memory built from a BRAM grid.
// Ports: CLK, RST (async, high), bus (slave). Macro SRAM_B_BYPASS_EN.
import sram_b_pkg::*;

module sram_b_banked_1w1r #(
  parameter int ABITS      = 18,
  parameter int DBITS      = 8,
  parameter int BANK_ABITS = 14,
  parameter int BANK_DBITS = 1,
  parameter int OUT_REG    = 0
) (
  input logic                 CLK,
  input logic                 RST,
  sram_b_banked_1w1r_if.slave bus
);

  localparam int NV = nv(ABITS, BANK_ABITS);
  localparam int NH = nh(DBITS, BANK_DBITS);
  localparam int SW = sel_w(ABITS, BANK_ABITS);
  localparam int PW = NH * BANK_DBITS;

  if (BANK_ABITS > ABITS) begin : g_bad_abits
    $error("sram_b: BANK_ABITS must not exceed ABITS");
  end
  if (SW > BANK_SEL_W) begin : g_bad_nv
    $error("sram_b: too many vertical banks");
  end

  logic [SW-1:0]         wsel, rsel, selv;
  logic [BANK_ABITS-1:0] ba0, ba1;
  logic [PW-1:0]         d_pad, m_pad;

  assign ba0   = bus.A0[BANK_ABITS-1:0];
  assign ba1   = bus.A1[BANK_ABITS-1:0];
  assign d_pad = PW'(bus.D0);
  assign m_pad = PW'(bus.WEM0);

  if (ABITS > BANK_ABITS) begin : g_sel
    assign wsel = bus.A0[ABITS-1:BANK_ABITS];
    assign rsel = bus.A1[ABITS-1:BANK_ABITS];
  end else begin : g_nosel
    assign wsel = '0;
    assign rsel = '0;
  end

  logic [BANK_DBITS-1:0] bq [NV][NH];

  for (genvar v = 0; v < NV; v++) begin : g_v
    logic       w_hit;
    bank_port_t rp;

    assign w_hit = (wsel == SW'(v));

    always_comb begin
      rp = '0;
      if (rsel == SW'(v)) begin
        rp.ce = bus.CE1;
        rp.a  = BANK_AW_MAX'(ba1);
      end
    end

    for (genvar h = 0; h < NH; h++) begin : g_h
      bank_port_t wp;

      always_comb begin
        wp = '0;
        if (w_hit) begin
          wp.ce  = bus.CE0;
          wp.a   = BANK_AW_MAX'(ba0);
          wp.d   = BANK_DW_MAX'(
                     d_pad[h*BANK_DBITS +: BANK_DBITS]);
          wp.we  = bus.WE0;
          wp.wem = BANK_DW_MAX'(
                     m_pad[h*BANK_DBITS +: BANK_DBITS]);
        end
      end

      sram_b_bank #(
        .ABITS(BANK_ABITS),
        .DBITS(BANK_DBITS)
      ) u_bank (
        .CLK(CLK),
        .p0 (wp),
        .p1 (rp),
        .q1 (bq[v][h])
      );
    end
  end

  logic rd_v;
  logic coll;

  assign coll = bus.CE0 & bus.WE0 & bus.CE1 &
                (bus.A0 == bus.A1);

  // rd_v follows CE1 every edge so valid is a one-cycle pulse;
  // selv only moves when a read is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_v <= 1'b0;
      selv <= '0;
    end else begin
      rd_v <= bus.CE1;
      if (bus.CE1) begin
        selv <= rsel;
      end
    end
  end

  logic [PW-1:0]    rdat;
  logic [DBITS-1:0] mdat;

  always_comb begin
    rdat = '0;
    for (int v = 0; v < NV; v++) begin
      if (selv == SW'(v)) begin
        for (int h = 0; h < NH; h++) begin
          rdat[h*BANK_DBITS +: BANK_DBITS] = bq[v][h];
        end
      end
    end
  end

  assign mdat = rdat[DBITS-1:0];

  if (PW > DBITS) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rdat[PW-1:DBITS];
  end

  logic [DBITS-1:0] word;

`ifdef SRAM_B_BYPASS_EN
  logic             hit;
  logic [DBITS-1:0] byp_d, byp_m;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit   <= 1'b0;
      byp_d <= '0;
      byp_m <= '0;
    end else if (bus.CE1) begin
      hit <= coll;
      if (coll) begin
        byp_d <= bus.D0;
        byp_m <= bus.WEM0;
      end
    end
  end

  // Masked-off bits are untouched by the write, so the bank's
  // old word is correct for them.
  assign word = hit ? ((byp_d & byp_m) | (mdat & ~byp_m))
                    : mdat;
`else
  assign word = mdat;
`endif

  logic [DBITS-1:0] q0;
  assign q0 = rd_v ? word : '0;

  if (OUT_REG != 0) begin : g_oreg
    logic [DBITS-1:0] q_r;
    logic             v_r;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_r <= '0;
        v_r <= 1'b0;
      end else begin
        v_r <= rd_v;
        if (rd_v) begin
          q_r <= q0;
        end
      end
    end

    assign bus.Q1       = q_r;
    assign bus.Q1_VALID = v_r;
  end else begin : g_noreg
    assign bus.Q1       = q0;
    assign bus.Q1_VALID = rd_v;
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (!RST) begin
      if ($isunknown({bus.CE0, bus.CE1})) begin
        $display("sram_b: X on CE0/CE1 at %0t", $time);
        $finish;
      end
      if ((bus.CE0 && $isunknown(bus.A0)) ||
          (bus.CE1 && $isunknown(bus.A1))) begin
        $display("sram_b: X address at %0t", $time);
        $finish;
      end
`ifndef SRAM_B_BYPASS_EN
      if (coll) begin
        $display("sram_b: address conflict at %0t", $time);
        $finish;
      end
`endif
    end
  end
`endif

endmodule

// File: tb/tb_sram_b_banked_1w1r.sv
// tb_sram_b_banked_1w1r: directed bench for the default geometry and a
// 10x12 / 512x8 / OUT_REG=1 geometry, with per-cycle memory models.
module tb_sram_b_banked_1w1r;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sram_b_banked_1w1r_if #(.ABITS(18), .DBITS(8)) d_if ();
  sram_b_banked_1w1r_if #(.ABITS(10), .DBITS(12)) g_if ();

  sram_b_banked_1w1r #(
    .ABITS(18), .DBITS(8), .BANK_ABITS(14),
    .BANK_DBITS(1), .OUT_REG(0)
  ) u_dut (
    .CLK(clk), .RST(rst), .bus(d_if.slave)
  );

  sram_b_banked_1w1r #(
    .ABITS(10), .DBITS(12), .BANK_ABITS(9),
    .BANK_DBITS(8), .OUT_REG(1)
  ) u_geo (
    .CLK(clk), .RST(rst), .bus(g_if.slave)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Memory contents as seen by a reader: word per address.
  bit [7:0]  dmem [int];
  bit [11:0] gmem [int];

  // Default geometry: result one cycle after the accepting edge.
  initial begin : model_d
    bit       ev;
    bit [7:0] eq, old;
    forever begin
      @(posedge clk);
      ev = 1'b0;
      eq = '0;
      if (!rst) begin
        if (d_if.CE0 && d_if.WE0) begin
          old = dmem.exists(int'(d_if.A0)) ?
                dmem[int'(d_if.A0)] : 8'h00;
          dmem[int'(d_if.A0)] = (d_if.D0 & d_if.WEM0) |
                                (old & ~d_if.WEM0);
        end
        if (d_if.CE1) begin
          ev = 1'b1;
          eq = dmem.exists(int'(d_if.A1)) ?
               dmem[int'(d_if.A1)] : 8'h00;
        end
      end
      #1;
      check("d_valid", 32'(d_if.Q1_VALID), 32'(ev));
      check("d_q1", 32'(d_if.Q1), 32'(eq));
    end
  end

  // Registered-output geometry: two cycles, data held between reads.
  initial begin : model_g
    bit        s1v, ov;
    bit [11:0] s1q, oq, old;
    s1v = 1'b0; ov = 1'b0; s1q = '0; oq = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        s1v = 1'b0; ov = 1'b0; s1q = '0; oq = '0;
      end else begin
        ov = s1v;
        if (s1v) oq = s1q;
        if (g_if.CE0 && g_if.WE0) begin
          old = gmem.exists(int'(g_if.A0)) ?
                gmem[int'(g_if.A0)] : 12'h000;
          gmem[int'(g_if.A0)] = (g_if.D0 & g_if.WEM0) |
                                (old & ~g_if.WEM0);
        end
        s1v = g_if.CE1;
        s1q = '0;
        if (g_if.CE1) begin
          s1q = gmem.exists(int'(g_if.A1)) ?
                gmem[int'(g_if.A1)] : 12'h000;
        end
      end
      #1;
      check("g_valid", 32'(g_if.Q1_VALID), 32'(ov));
      check("g_q1", 32'(g_if.Q1), 32'(oq));
    end
  end

  task automatic d_idle();
    d_if.CE0 = 1'b0; d_if.WE0 = 1'b0;
    d_if.A0 = '0; d_if.D0 = '0; d_if.WEM0 = '0;
    d_if.CE1 = 1'b0; d_if.A1 = '0;
  endtask

  task automatic g_idle();
    g_if.CE0 = 1'b0; g_if.WE0 = 1'b0;
    g_if.A0 = '0; g_if.D0 = '0; g_if.WEM0 = '0;
    g_if.CE1 = 1'b0; g_if.A1 = '0;
  endtask

  task automatic d_wr(input logic [17:0] a,
                      input logic [7:0] d,
                      input logic [7:0] m);
    @(negedge clk);
    d_idle();
    d_if.CE0 = 1'b1; d_if.WE0 = 1'b1;
    d_if.A0 = a; d_if.D0 = d; d_if.WEM0 = m;
  endtask

  task automatic d_rd(input logic [17:0] a);
    @(negedge clk);
    d_idle();
    d_if.CE1 = 1'b1; d_if.A1 = a;
  endtask

  task automatic d_lit(input string name,
                       input logic [7:0] exp);
    @(negedge clk);
    d_idle();
    check({name, "_q"}, 32'(d_if.Q1), 32'(exp));
    check({name, "_v"}, 32'(d_if.Q1_VALID), 32'd1);
  endtask

  task automatic g_wr(input logic [9:0] a,
                      input logic [11:0] d,
                      input logic [11:0] m);
    @(negedge clk);
    g_idle();
    g_if.CE0 = 1'b1; g_if.WE0 = 1'b1;
    g_if.A0 = a; g_if.D0 = d; g_if.WEM0 = m;
  endtask

  task automatic g_rd_chk(input string name,
                          input logic [9:0] a,
                          input logic [11:0] exp);
    @(negedge clk);
    g_idle();
    g_if.CE1 = 1'b1; g_if.A1 = a;
    @(negedge clk);
    g_idle();
    check({name, "_t1_v"}, 32'(g_if.Q1_VALID), 32'd0);
    @(negedge clk);
    check({name, "_q"}, 32'(g_if.Q1), 32'(exp));
    check({name, "_v"}, 32'(g_if.Q1_VALID), 32'd1);
    @(negedge clk);
    check({name, "_pulse"}, 32'(g_if.Q1_VALID), 32'd0);
    check({name, "_hold"}, 32'(g_if.Q1), 32'(exp));
  endtask

  function automatic logic [17:0] saddr(input int i);
    return 18'((i << 14) | (i * 5 + 'h200));
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    d_idle();
    g_idle();
    @(negedge clk);
    check("reset_q", 32'(d_if.Q1), 32'd0);
    check("reset_v", 32'(d_if.Q1_VALID), 32'd0);
    check("reset_gq", 32'(g_if.Q1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    d_wr(18'h00000, 8'hA5, 8'hFF);
    d_wr(18'h3FFFF, 8'hC3, 8'hFF);
    d_rd(18'h00000);
    d_lit("rd_a5", 8'hA5);
    d_rd(18'h3FFFF);
    d_lit("rd_c3", 8'hC3);
    @(negedge clk);
    check("rd_pulse", 32'(d_if.Q1_VALID), 32'd0);

    d_wr(18'h00012, 8'hFF, 8'hFF);
    d_wr(18'h00012, 8'h00, 8'h0F);
    d_rd(18'h00012);
    d_lit("mask", 8'hF0);

    d_wr(18'h00100, 8'h77, 8'hFF);
    d_rd(18'h00100);
    d_lit("wr_then_rd", 8'h77);

`ifdef SRAM_B_BYPASS_EN
    d_wr(18'h00040, 8'h11, 8'hFF);
    @(negedge clk);
    d_idle();
    d_if.CE0 = 1'b1; d_if.WE0 = 1'b1;
    d_if.A0 = 18'h00040; d_if.D0 = 8'h22;
    d_if.WEM0 = 8'hF0;
    d_if.CE1 = 1'b1; d_if.A1 = 18'h00040;
    d_lit("bypass", 8'h21);
    d_rd(18'h00040);
    d_lit("after_bypass", 8'h21);
`endif

    for (int i = 0; i < 16; i++) begin
      d_wr(saddr(i), 8'(8'h30 + i), 8'hFF);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d_idle();
      d_if.CE1 = 1'b1;
      d_if.A1 = saddr(i);
      if (i > 0) begin
        check("stream_v", 32'(d_if.Q1_VALID), 32'd1);
        check("stream_q", 32'(d_if.Q1),
              32'(8'(8'h30 + i - 1)));
      end
    end
    @(negedge clk);
    d_idle();
    check("stream_last_v", 32'(d_if.Q1_VALID), 32'd1);
    check("stream_last_q", 32'(d_if.Q1), 32'h3F);

    g_wr(10'h3FF, 12'hABC, 12'hFFF);
    g_rd_chk("geo_abc", 10'h3FF, 12'hABC);
    g_wr(10'h005, 12'h123, 12'hFFF);
    g_wr(10'h005, 12'hFFF, 12'h0F0);
    g_rd_chk("geo_mask", 10'h005, 12'h1F3);

    d_wr(18'h00005, 8'h5A, 8'hFF);
    d_rd(18'h00005);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_q", 32'(d_if.Q1), 32'd0);
    check("rst_async_v", 32'(d_if.Q1_VALID), 32'd0);
    @(negedge clk);
    check("rst_hold_v", 32'(d_if.Q1_VALID), 32'd0);
    @(negedge clk);
    d_idle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_q", 32'(d_if.Q1), 32'd0);
    check("rst_rel_v", 32'(d_if.Q1_VALID), 32'd0);

    d_rd(18'h00005);
    d_lit("post_rst", 8'h5A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
